// File: rtl/ac_pkg.sv
// Shared constants and helpers for the codec-to-system bridge.
package ac_pkg;
    localparam int ST_ADC_OVF   = 0;
    localparam int ST_DAC_UDF   = 1;
    localparam int ST_DAC_CHERR = 2;
    localparam int ST_W         = 3;

    // Channel index width; a single channel still needs a one-bit index field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ac_sync_fifo_if.sv
// Avalon-ST handshakes between the bridge (master) and the DSP side (slave).
interface ac_sync_fifo_if #(
    parameter int DATA_WDT = 24,
    parameter int CH_WDT   = 1
);
    logic                adcAsoValid;
    logic                adcAsoReady;
    logic [DATA_WDT-1:0] adcAsoData;
    logic [CH_WDT-1:0]   adcAsoChannel;
    logic                adcAsoSop;
    logic                adcAsoEop;
    logic                dacAsiValid;
    logic                dacAsiReady;
    logic [DATA_WDT-1:0] dacAsiData;
    logic [CH_WDT-1:0]   dacAsiChannel;

    modport master (
        output adcAsoValid, adcAsoData, adcAsoChannel, adcAsoSop, adcAsoEop, dacAsiReady,
        input  adcAsoReady, dacAsiValid, dacAsiData, dacAsiChannel
    );
    modport slave (
        input  adcAsoValid, adcAsoData, adcAsoChannel, adcAsoSop, adcAsoEop, dacAsiReady,
        output adcAsoReady, dacAsiValid, dacAsiData, dacAsiChannel
    );
endinterface

// File: rtl/ac_frame_fifo.sv
// Show-ahead synchronous frame FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module ac_frame_fifo #(
    parameter int WDT   = 48,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [WDT-1:0] wdata,
    input  logic           pop,
    output logic [WDT-1:0] rdata,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("ac_frame_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW:0]    wptr, rptr;
    logic [WDT-1:0] mem [DEPTH];
    logic           do_push, do_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/ac_sync_fifo.sv
// Codec frame bridge: tick synchroniser, ADC frame serialiser, DAC frame deserialiser and sticky status.
module ac_sync_fifo
    import ac_pkg::*;
#(
    parameter  int SYNC_DEPTH = 2,
    parameter  int DATA_WDT   = 24,
    parameter  int CH_NUM     = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int UDF_ZERO   = 1,
    localparam int CH_WDT     = clog2_min1(CH_NUM),
    localparam int FRM_WDT    = CH_NUM * DATA_WDT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acTick,
    input  logic [FRM_WDT-1:0] acAdcData,
    output logic [FRM_WDT-1:0] acDacData,
    input  logic               statusClr,
    output logic [ST_W-1:0]    status,
    ac_sync_fifo_if.master     bus
);
    if (SYNC_DEPTH < 2) begin : g_bad_sync
        $error("ac_sync_fifo: SYNC_DEPTH must be >= 2");
    end
    if (CH_NUM < 1) begin : g_bad_ch
        $error("ac_sync_fifo: CH_NUM must be >= 1");
    end

    logic [SYNC_DEPTH:0] syncTick;
    logic                tickD;

    always_ff @(posedge clk) begin
        if (reset) syncTick <= '0;
        else       syncTick <= {syncTick[SYNC_DEPTH-1:0], acTick};
    end
    assign tickD = syncTick[SYNC_DEPTH-1] & ~syncTick[SYNC_DEPTH];

    // ADC: whole frames queued, read out one channel per transfer
    logic [FRM_WDT-1:0] adcHead;
    logic               adcFull, adcEmpty, adcXfer, adcLast, adcPop;
    logic [CH_WDT-1:0]  adcCh;

    assign adcXfer = ~adcEmpty & bus.adcAsoReady;
    assign adcLast = (adcCh == CH_WDT'(CH_NUM - 1));
    assign adcPop  = adcXfer & adcLast;

    ac_frame_fifo #(.WDT(FRM_WDT), .DEPTH(FIFO_DEPTH)) u_adc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tickD),
        .wdata (acAdcData),
        .pop   (adcPop),
        .rdata (adcHead),
        .full  (adcFull),
        .empty (adcEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset)        adcCh <= '0;
        else if (adcXfer) adcCh <= adcLast ? '0 : adcCh + CH_WDT'(1);
    end

    assign bus.adcAsoValid   = ~adcEmpty;
    assign bus.adcAsoData    = adcEmpty ? '0 : adcHead[adcCh*DATA_WDT +: DATA_WDT];
    assign bus.adcAsoChannel = adcCh;
    assign bus.adcAsoSop     = ~adcEmpty & (adcCh == '0);
    assign bus.adcAsoEop     = ~adcEmpty & adcLast;

    // DAC: assemble samples into a frame; a complete frame waits in dacAsm until the FIFO takes it
    logic [FRM_WDT-1:0] dacAsm, dacHead, dacLastFrm;
    logic [CH_WDT-1:0]  dacExp;
    logic               dacPend, dacFull, dacEmpty, dacPush, dacPop, dacAcc, dacChOk;

    assign bus.dacAsiReady = ~dacFull | ~dacPend;
    assign dacAcc  = bus.dacAsiValid & bus.dacAsiReady;
    assign dacChOk = (bus.dacAsiChannel == dacExp);
    assign dacPop  = tickD & ~dacEmpty;
    assign dacPush = dacPend & (~dacFull | dacPop);

    ac_frame_fifo #(.WDT(FRM_WDT), .DEPTH(FIFO_DEPTH)) u_dac_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (dacPush),
        .wdata (dacAsm),
        .pop   (dacPop),
        .rdata (dacHead),
        .full  (dacFull),
        .empty (dacEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            dacAsm  <= '0;
            dacExp  <= '0;
            dacPend <= 1'b0;
        end else begin
            if (dacPush) dacPend <= 1'b0;
            if (dacAcc) begin
                if (dacChOk) begin
                    dacAsm[dacExp*DATA_WDT +: DATA_WDT] <= bus.dacAsiData;
                    if (dacExp == CH_WDT'(CH_NUM - 1)) begin
                        dacExp  <= '0;
                        dacPend <= 1'b1;
                    end else begin
                        dacExp <= dacExp + CH_WDT'(1);
                    end
                end else if (bus.dacAsiChannel == '0) begin
                    // Out-of-order channel 0 opens a fresh frame (never reached when CH_NUM == 1)
                    dacAsm[DATA_WDT-1:0] <= bus.dacAsiData;
                    dacExp               <= CH_WDT'(1);
                end else begin
                    dacExp <= '0;
                end
            end
        end
    end

    logic [ST_W-1:0] stSet;

    always_comb begin
        stSet               = '0;
        stSet[ST_ADC_OVF]   = tickD & adcFull & ~adcPop;
        stSet[ST_DAC_UDF]   = tickD & dacEmpty;
        stSet[ST_DAC_CHERR] = dacAcc & ~dacChOk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acDacData  <= '0;
            dacLastFrm <= '0;
            status     <= '0;
        end else begin
            if (tickD) begin
                if (!dacEmpty) begin
                    acDacData  <= dacHead;
                    dacLastFrm <= dacHead;
                end else begin
                    acDacData <= (UDF_ZERO != 0) ? '0 : dacLastFrm;
                end
            end
            // New events win over a simultaneous clear
            status <= (statusClr ? '0 : status) | stSet;
        end
    end
endmodule

// File: tb/tb_ac_sync_fifo.sv
// Bench for ac_sync_fifo: queue-based frame model compared every cycle plus directed literal checks.
module tb_ac_sync_fifo;
    localparam int SD = 2, DW = 24, CH = 2, DEPTH = 4, FW = CH * DW, CHW = 1;

    logic          clk = 0, reset = 1, acTick = 0, statusClr = 0;
    logic [FW-1:0] acAdcData = '0;
    logic [FW-1:0] acDacData;
    logic [2:0]    status;
    int            checks = 0, errors = 0;

    ac_sync_fifo_if #(.DATA_WDT(DW), .CH_WDT(CHW)) bus ();

    ac_sync_fifo #(.SYNC_DEPTH(SD), .DATA_WDT(DW), .CH_NUM(CH), .FIFO_DEPTH(DEPTH), .UDF_ZERO(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .acTick    (acTick),
        .acAdcData (acAdcData),
        .acDacData (acDacData),
        .statusClr (statusClr),
        .status    (status),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] frm(input int k);
        return {24'(k * 16 + 2), 24'(k * 16 + 1)};
    endfunction

    // Model: frames live in queues, tick event follows the sampled acTick history
    logic [FW-1:0] adcQ[$], dacQ[$];
    logic [FW-1:0] mpart, mpendFrm, mdacOut, mlast;
    logic [2:0]    mstat, mset;
    bit   [15:0]   hist;
    bit            started = 0, mpend, d, xfer, eopPop, acc;
    int            mch, mexp, ich;

    always @(posedge clk) begin
        if (reset) begin
            hist = '0; adcQ.delete(); dacQ.delete();
            mch = 0; mexp = 0; mpend = 0; mpart = '0; mpendFrm = '0;
            mdacOut = '0; mlast = '0; mstat = '0; started = 1;
        end else if (started) begin
            mset   = '0;
            d      = hist[SD-1] && !hist[SD];
            xfer   = (adcQ.size() != 0) && bus.adcAsoReady;
            eopPop = xfer && (mch == CH - 1);
            if (xfer) mch = (mch == CH - 1) ? 0 : mch + 1;
            if (eopPop) void'(adcQ.pop_front());
            if (d) begin
                if (adcQ.size() < DEPTH) adcQ.push_back(acAdcData);
                else mset[0] = 1'b1;
            end
            acc = bus.dacAsiValid && (!mpend || dacQ.size() < DEPTH);
            if (d) begin
                if (dacQ.size() != 0) begin
                    mdacOut = dacQ.pop_front();
                    mlast   = mdacOut;
                end else begin
                    mset[1] = 1'b1;
                    mdacOut = '0;
                end
            end
            if (mpend && dacQ.size() < DEPTH) begin
                dacQ.push_back(mpendFrm);
                mpend = 0;
            end
            if (acc) begin
                ich = int'(bus.dacAsiChannel);
                if (ich == mexp) begin
                    mpart[mexp*DW +: DW] = bus.dacAsiData;
                    if (mexp == CH - 1) begin
                        mpendFrm = mpart; mpend = 1; mexp = 0;
                    end else mexp++;
                end else begin
                    mset[2] = 1'b1;
                    if (ich == 0) begin
                        mpart[DW-1:0] = bus.dacAsiData; mexp = 1;
                    end else mexp = 0;
                end
            end
            mstat = (statusClr ? 3'b000 : mstat) | mset;
            hist  = {hist[14:0], acTick};
        end
    end

    // Transfer log taken from the DUT for the literal beat checks
    logic [26:0] beats[$];
    always @(posedge clk) begin
        if (started && !reset && bus.adcAsoValid && bus.adcAsoReady)
            beats.push_back({bus.adcAsoEop, bus.adcAsoSop, bus.adcAsoChannel, bus.adcAsoData});
    end

    logic [FW-1:0] head;
    always @(negedge clk) begin
        if (started) begin
            chk("adcValid", 64'(bus.adcAsoValid), 64'(adcQ.size() != 0));
            if (adcQ.size() != 0) begin
                head = adcQ[0];
                chk("adcData", 64'(bus.adcAsoData), 64'(head[mch*DW +: DW]));
                chk("adcChannel", 64'(bus.adcAsoChannel), 64'(mch));
                chk("adcSop", 64'(bus.adcAsoSop), 64'(mch == 0));
                chk("adcEop", 64'(bus.adcAsoEop), 64'(mch == CH - 1));
            end
            chk("dacReady", 64'(bus.dacAsiReady), 64'(!mpend || dacQ.size() < DEPTH));
            chk("acDacData", 64'(acDacData), 64'(mdacOut));
            chk("status", 64'(status), 64'(mstat));
        end
    end

    task automatic tick(input logic [FW-1:0] f);
        @(negedge clk); acAdcData = f; acTick = 1;
        repeat (3) @(negedge clk);
        acTick = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk); statusClr = 1;
        @(negedge clk); statusClr = 0;
    endtask

    task automatic dac_send(input int ch, input logic [DW-1:0] dv);
        int n = 0;
        @(negedge clk);
        bus.dacAsiValid = 1; bus.dacAsiChannel = CHW'(ch); bus.dacAsiData = dv;
        while (!bus.dacAsiReady && n < 20) begin @(negedge clk); n++; end
        chk("dac_ready_wait", 64'(bus.dacAsiReady), 64'(1));
        @(negedge clk); bus.dacAsiValid = 0;
    endtask

    int lat;
    initial begin
        bus.adcAsoReady = 0; bus.dacAsiValid = 0; bus.dacAsiData = '0; bus.dacAsiChannel = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.adcAsoValid), 64'(0));
        chk("rst_data", 64'(bus.adcAsoData), 64'(0));
        chk("rst_dac", 64'(acDacData), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_ready", 64'(bus.dacAsiReady), 64'(1));
        reset = 0;

        // 1: single frame, latency bound and beat contents
        bus.adcAsoReady = 1; beats.delete();
        @(negedge clk); acAdcData = {24'h000002, 24'h000001}; acTick = 1;
        lat = 0;
        for (int i = 1; i <= SD + 2 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.adcAsoValid) lat = i;
        end
        chk("t1_latency", 64'(lat != 0 && lat <= SD + 2), 64'(1));
        acTick = 0;
        repeat (6) @(negedge clk);
        chk("t1_beats", 64'(beats.size()), 64'(2));
        if (beats.size() >= 2) begin
            chk("t1_beat0", 64'(beats[0]), 64'({1'b0, 1'b1, 1'b0, 24'h000001}));
            chk("t1_beat1", 64'(beats[1]), 64'({1'b1, 1'b0, 1'b1, 24'h000002}));
        end

        // 2: overflow keeps four frames, drops the fifth
        clr(); bus.adcAsoReady = 0;
        for (int k = 1; k <= 5; k++) tick(frm(k));
        chk("t2_ovf", 64'(status[0]), 64'(1));
        beats.delete(); bus.adcAsoReady = 1;
        repeat (12) @(negedge clk);
        chk("t2_beats", 64'(beats.size()), 64'(8));
        if (beats.size() == 8)
            for (int k = 1; k <= 4; k++)
                chk("t2_order", 64'(beats[2*k-2][23:0]), 64'(k * 16 + 1));

        // 3: DAC frame out, then underflow
        clr();
        dac_send(0, -24'sd5);
        dac_send(1, 24'sd7);
        tick('0);
        chk("t3_dac", 64'(acDacData), 64'({24'h000007, 24'hFFFFFB}));
        chk("t3_noudf", 64'(status[1]), 64'(0));
        tick('0);
        chk("t3_udf", 64'(status[1]), 64'(1));
        chk("t3_zero", 64'(acDacData), 64'(0));

        // 4: repeated channel 0 restarts the frame
        clr();
        dac_send(0, 24'h111);
        dac_send(0, 24'h222);
        dac_send(1, 24'h333);
        chk("t4_cherr", 64'(status[2]), 64'(1));
        tick('0);
        chk("t4_dac", 64'(acDacData), 64'({24'h000333, 24'h000222}));

        // 5: EOP pop and tick push meet on a full ADC FIFO
        bus.adcAsoReady = 0; clr();
        for (int k = 6; k <= 9; k++) tick(frm(k));
        @(negedge clk); acAdcData = frm(10); acTick = 1;
        repeat (SD - 1) @(negedge clk);
        bus.adcAsoReady = 1;
        repeat (2) @(negedge clk);
        bus.adcAsoReady = 0; acTick = 0;
        repeat (3) @(negedge clk);
        chk("t5_noovf", 64'(status[0]), 64'(0));
        beats.delete(); bus.adcAsoReady = 1;
        repeat (12) @(negedge clk);
        chk("t5_beats", 64'(beats.size()), 64'(8));
        if (beats.size() == 8) chk("t5_last", 64'(beats[7][23:0]), 64'(10 * 16 + 2));

        // 6: reset mid-frame, then set-versus-clear priority
        clr(); bus.adcAsoReady = 0;
        tick(frm(11));
        chk("t6_pre_status", 64'(status[1]), 64'(1));
        @(negedge clk); bus.adcAsoReady = 1;
        @(negedge clk); bus.adcAsoReady = 0; reset = 1;
        @(negedge clk);
        chk("t6_valid", 64'(bus.adcAsoValid), 64'(0));
        chk("t6_status", 64'(status), 64'(0));
        reset = 0;
        @(negedge clk); acAdcData = frm(12); acTick = 1;
        repeat (SD) @(negedge clk);
        statusClr = 1;
        @(negedge clk); statusClr = 0; acTick = 0;
        chk("t6_setwins", 64'(status), 64'(3'b010));
        repeat (3) @(negedge clk);
        clr();
        chk("t6_cleared", 64'(status), 64'(0));

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
